// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operation codes,
// controller state encoding and a small decode helper.
package mips_muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFix  = 2'b10
    } md_state_e;

    // MULT and DIV take signed operands; MULTU and DIVU do not.
    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
// Multiply: acc holds {partial_hi, multiplier}; conditional add then shift right.
// Divide:   acc holds {remainder, quotient}; restoring shift-subtract.
module mips_muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_out
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] diff;

    // Select between shift-add and shift-subtract for this iteration.
    always_comb begin
        mul_sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
        rem_shift = acc_in[2*XLEN-1:XLEN-1];
        // Remainder stays below the divisor, so diff[XLEN] is a clean borrow flag.
        diff      = rem_shift - {1'b0, operand};
        if (is_div) begin
            if (diff[XLEN]) begin
                acc_out = {rem_shift[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end else begin
                acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_out = {mul_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO, busy/done
// handshake and pipeline stall generation.
module mips_muldiv_ctrl
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            md_start,
    input  logic [1:0]      md_op,
    input  logic [XLEN-1:0] md_a,
    input  logic [XLEN-1:0] md_b,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] mt_data,
    input  logic            mf_req,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            stall
);

    localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;

    md_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              div0_q, div0_d;
    logic              done_q, done_d;

    logic              signed_op;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    mips_muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div  (is_div_q),
        .acc_in  (acc_q),
        .operand (opnd_q),
        .acc_out (acc_step)
    );

    // Operand magnitudes at start and sign-corrected results for the FIX cycle.
    always_comb begin
        signed_op = is_signed_op(md_op);
        abs_a     = (signed_op && md_a[XLEN-1]) ? (~md_a + 1'b1) : md_a;
        abs_b     = (signed_op && md_b[XLEN-1]) ? (~md_b + 1'b1) : md_b;
        prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix   = rem_neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    end

    // Next-state logic: FSM, iteration counter, datapath and HI/LO writes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        dvd_d     = dvd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (md_start) begin
                    // A start in the same cycle as MTHI/MTLO drops the move.
                    is_div_d  = md_op[1];
                    neg_d     = signed_op && (md_a[XLEN-1] ^ md_b[XLEN-1]);
                    rem_neg_d = signed_op && md_a[XLEN-1];
                    div0_d    = (md_b == '0);
                    dvd_d     = md_a;
                    if (md_op[1]) begin
                        acc_d  = {{XLEN{1'b0}}, abs_a};
                        opnd_d = abs_b;
                    end else begin
                        acc_d  = {{XLEN{1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                    cnt_d   = CntW'(XLEN - 1);
                    state_d = StRun;
                end else begin
                    if (mthi) hi_d = mt_data;
                    if (mtlo) lo_d = mt_data;
                end
            end
            StRun: begin
                acc_d = acc_step;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFix: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (div0_q) begin
                    hi_d = dvd_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            dvd_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            dvd_q     <= dvd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign stall = busy & (md_start | mf_req | mthi | mtlo);

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Self-checking bench for mips_muldiv_ctrl: directed cases with literal
// expectations plus randomized traffic compared every cycle to a
// transaction-level model (full-width arithmetic, cycle countdown).
module tb_mips_muldiv_ctrl;
    import mips_muldiv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            md_start;
    logic [1:0]      md_op;
    logic [XLEN-1:0] md_a, md_b;
    logic            mthi, mtlo;
    logic [XLEN-1:0] mt_data;
    logic            mf_req;
    logic [XLEN-1:0] hi, lo;
    logic            busy, done, stall;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mips_muldiv_ctrl #(
        .XLEN (XLEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .mt_data  (mt_data),
        .mf_req   (mf_req),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} straight from arithmetic definitions.
    function automatic logic [63:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MD_MULT:  return 64'(sa * sb);
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
        endcase
    endfunction

    // Transaction-level model: busy countdown of XLEN+1 cycles then a done cycle.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    logic        m_busy, m_done;
    int          m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (md_start) begin
                m_busy <= 1'b1;
                m_left <= XLEN + 1;
                m_res  <= model_result(md_op, md_a, md_b);
            end else begin
                if (mthi) m_hi <= mt_data;
                if (mtlo) m_lo <= mt_data;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("stall", 64'(stall), 64'(m_busy & (md_start | mf_req | mthi | mtlo)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Start one operation and wait (bounded) for done; check latency and result.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int cyc;
        md_start = 1'b1; md_op = op; md_a = a; md_b = b;
        tick();
        md_start = 1'b0; md_a = $urandom; md_b = $urandom;
        for (cyc = 1; cyc <= 40 && !done; cyc++) tick();
        check({name, "_latency"}, 64'(cyc), 64'd34);
        check({name, "_hi"}, 64'(hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        rst = 1'b1; md_start = 1'b0; md_op = MD_MULT; md_a = '0; md_b = '0;
        mthi = 1'b0; mtlo = 1'b0; mt_data = '0; mf_req = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        rst = 1'b0;
        tick();

        run_op("mult_7_m3", MD_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
        run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by0", MD_DIVU, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("div_by0", MD_DIV, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
        run_op("divu_7_3", MD_DIVU, 32'd7, 32'd3, 32'd1, 32'd2);

        // Stall from mf_req while busy; a second start mid-operation is ignored.
        md_start = 1'b1; md_op = MD_MULT; md_a = 32'd7; md_b = 32'hFFFF_FFFD;
        tick();
        for (int n = 1; n <= 34; n++) begin
            md_start = (n == 10);
            md_op    = MD_DIVU;
            md_a     = $urandom;
            md_b     = $urandom;
            mf_req   = (n >= 5);
            #1;
            if (n >= 5) check("stall_mf", 64'(stall), (n <= 33) ? 64'd1 : 64'd0);
            if (n == 34) begin
                check("mf_done", 64'(done), 64'd1);
                check("mf_hi", 64'(hi), 64'hFFFF_FFFF);
                check("mf_lo", 64'(lo), 64'hFFFF_FFEB);
            end
            tick();
        end
        md_start = 1'b0; mf_req = 1'b0;
        tick();
        check("no_second_op", 64'(busy), 64'd0);

        // MTHI/MTLO in idle, MTLO ignored while busy.
        mthi = 1'b1; mt_data = 32'h1234_5678;
        tick();
        mthi = 1'b0;
        check("mthi_idle", 64'(hi), 64'h1234_5678);
        mtlo = 1'b1; mt_data = 32'hCAFE_F00D;
        tick();
        mtlo = 1'b0;
        check("mtlo_idle", 64'(lo), 64'hCAFE_F00D);
        md_start = 1'b1; md_op = MD_MULTU; md_a = 32'd3; md_b = 32'd5;
        tick();
        md_start = 1'b0;
        tick();
        mtlo = 1'b1; mt_data = 32'hDEAD_BEEF;
        #1;
        check("mtlo_busy_stall", 64'(stall), 64'd1);
        tick();
        mtlo = 1'b0;
        check("mtlo_busy_lo", 64'(lo), 64'hCAFE_F00D);
        for (int k = 0; k < 40 && !done; k++) tick();
        check("multu_3_5_lo", 64'(lo), 64'd15);

        // Start beats a simultaneous MTHI.
        md_start = 1'b1; md_op = MD_MULTU; md_a = 32'd2; md_b = 32'd3;
        mthi = 1'b1; mt_data = 32'h5555_5555;
        tick();
        md_start = 1'b0; mthi = 1'b0;
        check("start_wins_hi", 64'(hi), 64'd0);
        for (int k = 0; k < 40 && !done; k++) tick();
        check("start_wins_lo", 64'(lo), 64'd6);

        // Reset in the middle of a divide abandons it.
        md_start = 1'b1; md_op = MD_DIV; md_a = 32'd1000; md_b = 32'd7;
        tick();
        md_start = 1'b0;
        for (int n = 1; n < 20; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        for (int n = 0; n < 40; n++) begin
            if (done) check("rst_no_done", 64'(done), 64'd0);
            tick();
        end

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom_range(0, 399) == 0);
            md_start = ($urandom_range(0, 5) == 0);
            md_op    = 2'($urandom_range(0, 3));
            md_a     = pick_val();
            md_b     = pick_val();
            mthi     = ($urandom_range(0, 7) == 0);
            mtlo     = ($urandom_range(0, 7) == 0);
            mt_data  = $urandom;
            mf_req   = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b0; md_start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mf_req = 1'b0;
        for (int n = 0; n < 40; n++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_ctrl.md
MIPS_MULDIV_CTRL -- requirements
Module: mips_muldiv_ctrl

Interface
REQ-001 Parameter XLEN, default 32, operand and HI/LO width; the iteration count equals XLEN.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, as listed below.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 md_start  in  1  request to start an operation, decoded from MULT/MULTU/DIV/DIVU.
REQ-006 md_op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 md_a  in  XLEN  rs_data (multiplicand or dividend).
REQ-008 md_b  in  XLEN  rt_data (multiplier or divisor).
REQ-009 mthi / mtlo  in  1 each  write mt_data to HI or LO (from hi_en/lo_en).
REQ-010 mt_data  in  XLEN  rs_data for MTHI/MTLO.
REQ-011 mf_req  in  1  MFHI or MFLO is in decode (memtoreg 10/11).
REQ-012 hi / lo  out  XLEN  architectural HI and LO registers.
REQ-013 busy  out  1  operation in progress.
REQ-014 done  out  1  one-cycle pulse; HI/LO hold the new result.
REQ-015 stall  out  1  core must hold the current instruction.

Function
REQ-016 FSM states SHALL be IDLE, RUN and FIX, with reset state IDLE.
REQ-017 IDLE with md_start=1: latch |md_a| and |md_b| (or the raw values for unsigned ops), the result signs, op and a divide-by-zero flag; load counter with XLEN-1; go to RUN.
REQ-018 RUN: perform one radix-2 step per cycle; multiply is shift-add into a 2*XLEN product; divide is restoring shift-subtract (remainder, quotient).
REQ-019 RUN: decrement the counter each cycle; on counter=0, go to FIX. RUN lasts exactly XLEN cycles.
REQ-020 FIX: apply sign correction, write HI/LO at the end of the cycle, go to IDLE.
REQ-021 Latency: if start is sampled at the end of cycle 0, busy=1 in cycles 1..XLEN+1, and hi/lo are updated with done=1 in cycle XLEN+2 (34 for XLEN=32).
REQ-022 Multiply result: HI = product[2*XLEN-1:XLEN], LO = product[XLEN-1:0]. Signed: negate the 2*XLEN product if the operand signs differ.
REQ-023 Divide result: LO = quotient, HI = remainder. Signed: negate the quotient if the signs differ; the remainder takes the dividend's sign.
REQ-024 Divide by zero, signed or unsigned: LO = all ones, HI = md_a unmodified; no sign fix; latency unchanged.
REQ-025 Signed DIV 0x80000000 / -1 SHALL yield LO=0x80000000 and HI=0.
REQ-026 stall = busy & (md_start | mf_req | mthi | mtlo), combinational.
REQ-027 In the done cycle, busy=0 and stall=0; mf_req reads the new value.
REQ-028 md_start, mthi and mtlo SHALL be ignored while busy.
REQ-029 mthi/mtlo in IDLE: update HI/LO at the edge; visible next cycle.
REQ-030 md_start together with mthi/mtlo in the same IDLE cycle: md_start wins; the mt write is dropped.
REQ-031 done SHALL be registered and high for exactly one cycle per completed operation.

Reset
REQ-032 rst SHALL force state=IDLE, hi=0, lo=0, busy=0, done=0 and counter=0; stall is consequently 0.
REQ-033 rst asserted in RUN or FIX SHALL abandon the operation; HI/LO go to 0 and no done pulse follows.
REQ-034 rst SHALL take priority over md_start, mthi and mtlo in the same cycle.

Structure
REQ-035 The shared package SHALL hold the md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the FSM state enum.
REQ-036 Sub-module mips_muldiv_step SHALL implement the combinational single-iteration add/subtract-shift; the FSM, counter and HI/LO stay in the top module.
REQ-037 Outputs busy and done SHALL be derived from registered state only.

Verification
REQ-038 MULT 7 x 0xFFFFFFFD -> done in cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-039 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-040 DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064.
REQ-041 MULT started, then mf_req=1 in cycle 5 -> stall=1 in cycles 5..33 and 0 in cycle 34; a second md_start in cycle 10 is ignored.
REQ-042 MTHI 0x12345678 in IDLE -> hi=0x12345678 next cycle; MTLO during busy -> lo unchanged, stall=1.
REQ-043 DIV started, rst in cycle 20 -> state IDLE, hi=lo=0 next cycle, and no done pulse ever follows.
